// File: rtl/ffe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ffe_pkg
// Brief   : Shared widths, init defaults and controller state encoding.
// Revision: 1.0
// ============================================================================
package ffe_pkg;

  localparam int COEF_BW     = 9;
  localparam int N_COEF      = 7;
  localparam int DELTA_BW    = 9;
  localparam int TAP_BW      = $clog2(N_COEF);
  localparam int CENTER_TAP  = 3;
  localparam int INIT_CENTER = 128;

  localparam int COEF_MAX = (1 << (COEF_BW - 1)) - 1;
  localparam int COEF_MIN = -(1 << (COEF_BW - 1));

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/coef_sat_add.sv
`default_nettype none
// ============================================================================
// Module  : coef_sat_add
// Brief   : Signed coefficient + delta with clamp to the coefficient range.
// Revision: 1.0
// ============================================================================
module coef_sat_add #(
  parameter int COEF_BW  = 9,
  parameter int DELTA_BW = 9
) (
  input  logic [COEF_BW-1:0]  coef_i,
  input  logic [DELTA_BW-1:0] delta_i,
  output logic [COEF_BW-1:0]  coef_o,
  output logic                ovf_o
);

  // One guard bit above the wider operand makes the sum exact.
  localparam int SUM_BW = ((COEF_BW > DELTA_BW) ? COEF_BW : DELTA_BW) + 1;
  localparam logic signed [SUM_BW-1:0] SUM_MAX = SUM_BW'((1 << (COEF_BW - 1)) - 1);
  localparam logic signed [SUM_BW-1:0] SUM_MIN = SUM_BW'(-(1 << (COEF_BW - 1)));

  logic signed [SUM_BW-1:0] sum;

  always_comb begin
    sum = $signed({{(SUM_BW - COEF_BW){coef_i[COEF_BW-1]}}, coef_i})
        + $signed({{(SUM_BW - DELTA_BW){delta_i[DELTA_BW-1]}}, delta_i});
    coef_o = sum[COEF_BW-1:0];
    ovf_o  = 1'b0;
    if (sum > SUM_MAX) begin
      coef_o = SUM_MAX[COEF_BW-1:0];
      ovf_o  = 1'b1;
    end else if (sum < SUM_MIN) begin
      coef_o = SUM_MIN[COEF_BW-1:0];
      ovf_o  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ffe_coef_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ffe_coef_ctrl
// Brief   : FFE coefficient owner: host shadow bank, symbol-aligned atomic
//           commit to the active bank, and saturating LMS tap updates.
// Revision: 1.0
// ============================================================================
module ffe_coef_ctrl #(
  parameter int COEF_BW     = ffe_pkg::COEF_BW,
  parameter int N_COEF      = ffe_pkg::N_COEF,
  parameter int CENTER_TAP  = ffe_pkg::CENTER_TAP,
  parameter int INIT_CENTER = ffe_pkg::INIT_CENTER,
  parameter int DELTA_BW    = ffe_pkg::DELTA_BW,
  parameter int TAP_BW      = $clog2(N_COEF)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_init,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [TAP_BW-1:0]         i_wr_addr,
  input  logic [COEF_BW-1:0]        i_wr_data,
  input  logic                      i_commit,
  output logic                      o_commit_done,
  input  logic                      i_adapt_en,
  input  logic                      i_lms_valid,
  input  logic [TAP_BW-1:0]         i_lms_tap,
  input  logic [DELTA_BW-1:0]       i_lms_delta,
  output logic                      o_lms_drop,
  output logic [COEF_BW*N_COEF-1:0] o_coefs,
  output logic                      o_busy,
  output logic                      o_sat,
  output logic                      o_wr_err
);

  import ffe_pkg::*;

  localparam logic [TAP_BW:0]   N_EXT    = (TAP_BW + 1)'(N_COEF);
  localparam logic [TAP_BW-1:0] LAST_TAP = TAP_BW'(N_COEF - 1);
  localparam logic [TAP_BW-1:0] CTR_TAP  = TAP_BW'(CENTER_TAP);

  state_t              state_q, state_d;
  logic [TAP_BW-1:0]   cnt_q, cnt_d;
  logic [COEF_BW-1:0]  shadow_q [N_COEF];
  logic [COEF_BW-1:0]  shadow_d [N_COEF];
  logic [COEF_BW-1:0]  active_q [N_COEF];
  logic [COEF_BW-1:0]  active_d [N_COEF];
  logic                sat_q, sat_d;
  logic                wr_err_q, wr_err_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;

  logic                lms_req;
  logic                wr_addr_ok;
  logic                lms_tap_ok;
  logic [COEF_BW-1:0]  init_val;
  logic [COEF_BW-1:0]  lms_cur;
  logic [COEF_BW-1:0]  lms_sum;
  logic                lms_ovf;

  assign lms_req    = i_adapt_en & i_lms_valid;
  assign wr_addr_ok = {1'b0, i_wr_addr} < N_EXT;
  assign lms_tap_ok = {1'b0, i_lms_tap} < N_EXT;
  assign init_val   = (cnt_q == CTR_TAP) ? COEF_BW'(INIT_CENTER) : '0;
  assign lms_cur    = lms_tap_ok ? active_q[i_lms_tap] : '0;

  coef_sat_add #(
    .COEF_BW  (COEF_BW),
    .DELTA_BW (DELTA_BW)
  ) u_sat_add (
    .coef_i  (lms_cur),
    .delta_i (i_lms_delta),
    .coef_o  (lms_sum),
    .ovf_o   (lms_ovf)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    sat_d    = sat_q;
    wr_err_d = wr_err_q;
    done_d   = 1'b0;
    drop_d   = lms_req & (state_q != ST_RUN);

    // Re-init overrides any commit or write presented in the same cycle.
    if (i_init) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          shadow_d[cnt_q] = init_val;
          active_d[cnt_q] = init_val;
          sat_d           = 1'b0;
          wr_err_d        = 1'b0;
          if (cnt_q == LAST_TAP) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (i_wr_valid) begin
            if (wr_addr_ok) shadow_d[i_wr_addr] = i_wr_data;
            else            wr_err_d            = 1'b1;
          end
          if (lms_req && lms_tap_ok) begin
            active_d[i_lms_tap] = lms_sum;
            if (lms_ovf) sat_d = 1'b1;
          end
          if (i_commit) state_d = ST_PEND;
        end
        ST_PEND: begin
          if (i_en) begin
            active_d = shadow_q;
            done_d   = 1'b1;
            state_d  = ST_RUN;
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      wr_err_q <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      for (int k = 0; k < N_COEF; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      wr_err_q <= wr_err_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  generate
    for (genvar k = 0; k < N_COEF; k++) begin : g_pack
      assign o_coefs[COEF_BW*k +: COEF_BW] = active_q[k];
    end
  endgenerate

  assign o_wr_ready    = (state_q == ST_RUN) & ~i_init;
  assign o_busy        = (state_q != ST_RUN);
  assign o_commit_done = done_q;
  assign o_lms_drop    = drop_q;
  assign o_sat         = sat_q;
  assign o_wr_err      = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ffe_coef_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ffe_coef_ctrl
// Brief   : Directed bench for ffe_coef_ctrl with a cycle-level bank model.
// Revision: 1.0
// ============================================================================
module tb_ffe_coef_ctrl;

  localparam int N = 7;
  localparam logic [62:0] INIT_COEFS = 63'h0000_0004_0000_0000;

  logic        clk = 1'b0;
  logic        rst, en, ini, wr_valid, commit, adapt, lms_valid;
  logic [2:0]  wr_addr, lms_tap;
  logic [8:0]  wr_data, lms_delta;
  logic        wr_ready, commit_done, lms_drop, busy, sat, wr_err;
  logic [62:0] coefs;

  int errors = 0;
  int checks = 0;

  // Model: remaining init steps, pending flag, both banks as plain integers.
  int m_init_left;
  bit m_pend;
  int m_sh [N];
  int m_ac [N];
  bit m_sat, m_err, m_done, m_drop;

  ffe_coef_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_init        (ini),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_commit      (commit),
    .o_commit_done (commit_done),
    .i_adapt_en    (adapt),
    .i_lms_valid   (lms_valid),
    .i_lms_tap     (lms_tap),
    .i_lms_delta   (lms_delta),
    .o_lms_drop    (lms_drop),
    .o_coefs       (coefs),
    .o_busy        (busy),
    .o_sat         (sat),
    .o_wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [62:0] pack_model();
    logic [62:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[9*k +: 9] = 9'(m_ac[k]);
    return p;
  endfunction

  task automatic model_step();
    bit running;
    int s;
    if (rst) begin
      m_init_left = N;
      m_pend = 0; m_sat = 0; m_err = 0; m_done = 0; m_drop = 0;
      for (int k = 0; k < N; k++) begin m_sh[k] = 0; m_ac[k] = 0; end
      return;
    end
    running = (m_init_left == 0) && !m_pend;
    m_done  = 0;
    m_drop  = adapt && lms_valid && !running;
    if (ini) begin
      m_init_left = N;
      m_pend = 0;
      return;
    end
    if (m_init_left > 0) begin
      s = N - m_init_left;
      m_sh[s] = (s == 3) ? 128 : 0;
      m_ac[s] = m_sh[s];
      m_sat = 0; m_err = 0;
      m_init_left--;
    end else if (m_pend) begin
      if (en) begin
        for (int k = 0; k < N; k++) m_ac[k] = m_sh[k];
        m_pend = 0;
        m_done = 1;
      end
    end else begin
      if (wr_valid) begin
        if (int'(wr_addr) < N) m_sh[wr_addr] = int'($signed(wr_data));
        else m_err = 1;
      end
      if (adapt && lms_valid && int'(lms_tap) < N) begin
        s = m_ac[lms_tap] + int'($signed(lms_delta));
        if (s > 255) begin s = 255; m_sat = 1; end
        else if (s < -256) begin s = -256; m_sat = 1; end
        m_ac[lms_tap] = s;
      end
      if (commit) m_pend = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("coefs", coefs, pack_model());
    chk("busy", busy, (m_init_left > 0) || m_pend);
    chk("wr_ready", wr_ready, !((m_init_left > 0) || m_pend) && !ini);
    chk("sat", sat, m_sat);
    chk("wr_err", wr_err, m_err);
    chk("commit_done", commit_done, m_done);
    chk("lms_drop", lms_drop, m_drop);
  end

  initial begin
    int busy_cycles;
    bit left_init;
    rst = 1; en = 0; ini = 0; wr_valid = 0; commit = 0; adapt = 0; lms_valid = 0;
    wr_addr = 0; lms_tap = 0; wr_data = 0; lms_delta = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("lit_rst_busy", busy, 1);
    chk("lit_rst_coefs", coefs, 0);
    tick();
    rst = 0;

    busy_cycles = 0;
    left_init = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin left_init = 1; break; end
      busy_cycles++;
    end
    chk("lit_init_exit", left_init, 1);
    chk("lit_busy_cycles", busy_cycles, 7);
    chk("lit_init_coefs", coefs, INIT_COEFS);
    chk("lit_ready", wr_ready, 1);

    // host writes, then a commit held off by i_en
    tick(); wr_valid = 1; wr_addr = 0; wr_data = 9'h1FB;
    tick(); wr_addr = 6; wr_data = 9'd100;
    tick(); wr_valid = 0; commit = 1;
    tick(); commit = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("lit_coefs_hold", coefs, INIT_COEFS);
    end
    en = 1;
    tick(); en = 0;
    @(negedge clk);
    chk("lit_tap0_commit", coefs[8:0], 9'h1FB);
    chk("lit_tap6_commit", coefs[62:54], 9'd100);
    chk("lit_done", commit_done, 1);

    // LMS saturation high then low
    tick(); adapt = 1; lms_valid = 1; lms_tap = 3; lms_delta = 9'd200;
    tick(); lms_valid = 0;
    @(negedge clk);
    chk("lit_tap3_sat_hi", coefs[35:27], 9'd255);
    chk("lit_sat", sat, 1);
    tick(); lms_valid = 1; lms_delta = 9'h100;
    tick();
    tick(); lms_delta = 9'h1F6;
    tick(); lms_valid = 0;
    @(negedge clk);
    chk("lit_tap3_sat_lo", coefs[35:27], 9'h100);

    // out-of-range LMS tap, then an ordinary update
    tick(); lms_valid = 1; lms_tap = 7; lms_delta = 9'd50;
    tick(); lms_tap = 5; lms_delta = 9'h1F0;
    tick(); lms_valid = 0; commit = 1;

    // LMS while a commit is pending is dropped
    tick(); commit = 0; lms_valid = 1; lms_tap = 3; lms_delta = 9'd5;
    tick();
    @(negedge clk);
    chk("lit_drop", lms_drop, 1);
    chk("lit_tap3_pend", coefs[35:27], 9'h100);
    tick(); lms_valid = 0; en = 1;
    tick(); en = 0;
    @(negedge clk);
    chk("lit_tap3_overwritten", coefs[35:27], 9'd128);

    // write to an invalid address
    tick(); wr_valid = 1; wr_addr = 7; wr_data = 9'd55;
    tick(); wr_valid = 0;
    @(negedge clk);
    chk("lit_wr_err", wr_err, 1);

    // write and commit in the same cycle
    tick(); wr_valid = 1; wr_addr = 2; wr_data = 9'd77; commit = 1; en = 1;
    tick(); wr_valid = 0; commit = 0;
    tick(); en = 0;
    @(negedge clk);
    chk("lit_tap2_same_cycle", coefs[26:18], 9'd77);

    // re-init clears the sticky error
    tick(); ini = 1;
    tick(); ini = 0;
    repeat (8) tick();
    @(negedge clk);
    chk("lit_wr_err_cleared", wr_err, 0);
    chk("lit_reinit_coefs", coefs, INIT_COEFS);

    // re-init while a commit is pending
    tick(); wr_valid = 1; wr_addr = 1; wr_data = 9'd33;
    tick(); wr_valid = 0; commit = 1;
    tick(); commit = 0;
    tick(); ini = 1;
    tick(); ini = 0;
    @(negedge clk);
    chk("lit_busy_reinit", busy, 1);
    chk("lit_no_done", commit_done, 0);
    repeat (8) tick();
    commit = 1; en = 1;
    tick(); commit = 0;
    tick(); en = 0;
    @(negedge clk);
    chk("lit_shadow_lost", coefs, INIT_COEFS);
    chk("lit_done_after_reinit", commit_done, 1);

    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
